// File: rtl/ntr_pkg.sv
// ntr_pkg: shared definitions for the NTR command-capture block.
//   - capture state enum (IDLE / CMD / DATA)
//   - default bus geometry: NTR_DATA_W-bit words, NTR_CMD_BYTES words per command
`timescale 1ns/1ps
package ntr_pkg;

    localparam int NTR_CMD_BYTES = 8;
    localparam int NTR_DATA_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } ntr_state_e;

endpackage

// File: rtl/ntr_cmd_capture_if.sv
// ntr_cmd_capture_if: groups the NTR pin bundle and the command stream.
//   ntr_clk / ntr_cs1 / ntr_data : raw NTR bus pins (cs1 active-low)
//   cmd_data / cmd_valid / cmd_ready : first-word-fall-through command stream
// Modports: master = bus host + command consumer, slave = capture block.
`timescale 1ns/1ps
interface ntr_cmd_capture_if
    import ntr_pkg::*;
#(
    parameter int DATA_W    = NTR_DATA_W,
    parameter int CMD_BYTES = NTR_CMD_BYTES
);
    logic                          ntr_clk;
    logic                          ntr_cs1;
    logic [DATA_W-1:0]             ntr_data;
    logic [CMD_BYTES*DATA_W-1:0]   cmd_data;
    logic                          cmd_valid;
    logic                          cmd_ready;

    modport master (
        output ntr_clk, ntr_cs1, ntr_data, cmd_ready,
        input  cmd_data, cmd_valid
    );

    modport slave (
        input  ntr_clk, ntr_cs1, ntr_data, cmd_ready,
        output cmd_data, cmd_valid
    );
endinterface

// File: rtl/ntr_cmd_fifo.sv
// ntr_cmd_fifo: first-word-fall-through command FIFO.
//   push/wdata : write request (dropped with drop=1 when full and not popping)
//   pop        : remove head (ignored when empty)
//   rdata      : head entry, valid while level != 0
//   level      : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
`timescale 1ns/1ps
module ntr_cmd_fifo
    import ntr_pkg::*;
#(
    parameter int WIDTH = NTR_CMD_BYTES * NTR_DATA_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             full, wr_en, rd_en;

    always_comb begin
        full     = (level_q == (AW+1)'(DEPTH));
        rd_en    = pop & (level_q != '0);
        // A pop in the same cycle frees the slot a full FIFO needs.
        wr_en    = push & (~full | rd_en);
        drop     = push & full & ~rd_en;
        wr_ptr_d = wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({wr_en, rd_en})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; validity is tracked by level_q alone.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign valid = (level_q != '0);
    assign level = level_q;
endmodule

// File: rtl/ntr_cmd_capture.sv
// ntr_cmd_capture: captures NTR bus commands into a command FIFO.
//   clk, rst      : system clock, async active-high reset
//   bus (slave)   : NTR pins in, command stream out (FWFT, pop on valid&ready)
//   data_count    : data words seen after the command in the current select
//   fifo_level    : stored commands
//   overflow      : sticky, a complete command was dropped; clear_ovf clears it
//   abort         : one-cycle pulse when a partial command is discarded
`timescale 1ns/1ps
module ntr_cmd_capture
    import ntr_pkg::*;
#(
    parameter int DATA_W      = NTR_DATA_W,
    parameter int CMD_BYTES   = NTR_CMD_BYTES,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_RISE   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    ntr_cmd_capture_if.slave              bus,
    output logic [15:0]                   data_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          abort,
    input  logic                          clear_ovf
);
    localparam int   CMD_W    = CMD_BYTES * DATA_W;
    localparam int   CNT_W    = $clog2(CMD_BYTES);
    localparam int   SET_W    = $clog2(SYNC_STAGES + 1);
    localparam logic CLK_IDLE = (EDGE_RISE != 0) ? 1'b0 : 1'b1;

    logic [SYNC_STAGES-1:0]             clk_sync_q, clk_sync_d, cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] data_sync_q, data_sync_d;
    logic              clk_s, cs_s;
    logic [DATA_W-1:0] data_s;
    logic              clk_prev_q, clk_prev_d, cs_hi_q, cs_hi_d, cs_fall_q, cs_fall_d;
    logic              strobe_q, strobe_d, armed_q, armed_d;
    logic [SET_W-1:0]  settle_q, settle_d;
    logic [DATA_W-1:0] word_q, word_d;
    ntr_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CMD_W-1:0]  shift_q, shift_d;
    logic [15:0]       data_count_q, data_count_d;
    logic              push_q, push_d, abort_q, abort_d, overflow_q, overflow_d;
    logic              pop, fifo_valid, fifo_drop;
    logic [CMD_W-1:0]  fifo_rdata;

    // ---- stage: pin synchronisers and event detection ----
    always_comb begin
        clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], bus.ntr_clk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.ntr_cs1};
        data_sync_d = {data_sync_q[SYNC_STAGES-2:0], bus.ntr_data};
        clk_s       = clk_sync_q[SYNC_STAGES-1];
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        data_s      = data_sync_q[SYNC_STAGES-1];
        clk_prev_d  = clk_s;
        cs_hi_d     = cs_s;
        word_d      = data_s;
        strobe_d    = ((EDGE_RISE != 0) ? (clk_s & ~clk_prev_q) : (~clk_s & clk_prev_q)) & ~cs_s;
        // After reset the chains hold idle levels; a select that was already
        // low would look like a falling edge once flushed. Arm only after a
        // genuine high level has been seen through a flushed chain.
        settle_d    = (settle_q == SET_W'(SYNC_STAGES)) ? settle_q : settle_q + SET_W'(1);
        armed_d     = armed_q | ((settle_q == SET_W'(SYNC_STAGES)) & cs_s);
        cs_fall_d   = armed_q & cs_hi_q & ~cs_s;
    end

    // ---- stage: capture state machine ----
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        data_count_d = data_count_q;
        push_d       = 1'b0;
        abort_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall_q) begin
                    state_d      = CMD;
                    cnt_d        = '0;
                    data_count_d = '0;
                end
            end
            CMD: begin
                if (cs_hi_q) begin
                    state_d = IDLE;
                    abort_d = 1'b1;
                end else if (strobe_q) begin
                    shift_d = {shift_q[CMD_W-DATA_W-1:0], word_q};
                    if (cnt_q == CNT_W'(CMD_BYTES - 1)) begin
                        state_d = DATA;
                        push_d  = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (cs_hi_q) begin
                    state_d = IDLE;
                end else if (strobe_q && data_count_q != 16'hFFFF) begin
                    data_count_d = data_count_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Sticky flag: a new drop wins over a simultaneous clear.
        overflow_d = fifo_drop | (overflow_q & ~clear_ovf);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q   <= {SYNC_STAGES{CLK_IDLE}};
            cs_sync_q    <= '1;
            data_sync_q  <= '0;
            clk_prev_q   <= CLK_IDLE;
            cs_hi_q      <= 1'b1;
            cs_fall_q    <= 1'b0;
            strobe_q     <= 1'b0;
            armed_q      <= 1'b0;
            settle_q     <= '0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            data_count_q <= '0;
            push_q       <= 1'b0;
            abort_q      <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            cs_sync_q    <= cs_sync_d;
            data_sync_q  <= data_sync_d;
            clk_prev_q   <= clk_prev_d;
            cs_hi_q      <= cs_hi_d;
            cs_fall_q    <= cs_fall_d;
            strobe_q     <= strobe_d;
            armed_q      <= armed_d;
            settle_q     <= settle_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            data_count_q <= data_count_d;
            push_q       <= push_d;
            abort_q      <= abort_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        word_q  <= word_d;
        shift_q <= shift_d;
    end

    // ---- stage: command FIFO (push one cycle after the last word) ----
    assign pop = fifo_valid & bus.cmd_ready;

    ntr_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_q),
        .wdata (shift_q),
        .pop   (pop),
        .rdata (fifo_rdata),
        .valid (fifo_valid),
        .level (fifo_level),
        .drop  (fifo_drop)
    );

    assign bus.cmd_data  = fifo_rdata;
    assign bus.cmd_valid = fifo_valid;
    assign data_count    = data_count_q;
    assign overflow      = overflow_q;
    assign abort         = abort_q;
endmodule

// File: tb/tb_ntr_cmd_capture.sv
`timescale 1ns/1ps
module tb_ntr_cmd_capture;
    import ntr_pkg::*;

    localparam int DW = 8;
    localparam int CB = 8;
    localparam int FD = 4;
    localparam int SS = 2;

    typedef logic [DW-1:0] word_arr_t [CB];

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ntr_cmd_capture_if #(.DATA_W(DW), .CMD_BYTES(CB)) ifa ();
    ntr_cmd_capture_if #(.DATA_W(DW), .CMD_BYTES(CB)) ifb ();

    logic [15:0] dc_a, dc_b;
    logic [2:0]  lvl_a, lvl_b;
    logic        ovf_a, ovf_b, ab_a, ab_b;
    logic        clr_a, clr_b;

    ntr_cmd_capture #(.DATA_W(DW), .CMD_BYTES(CB), .FIFO_DEPTH(FD), .SYNC_STAGES(SS), .EDGE_RISE(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave), .data_count(dc_a), .fifo_level(lvl_a),
        .overflow(ovf_a), .abort(ab_a), .clear_ovf(clr_a));

    ntr_cmd_capture #(.DATA_W(DW), .CMD_BYTES(CB), .FIFO_DEPTH(FD), .SYNC_STAGES(SS), .EDGE_RISE(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave), .data_count(dc_b), .fifo_level(lvl_b),
        .overflow(ovf_b), .abort(ab_b), .clear_ovf(clr_b));

    int ab_cnt_a = 0;
    int ab_cnt_b = 0;
    always @(negedge clk) begin
        if (ab_a === 1'b1) ab_cnt_a++;
        if (ab_b === 1'b1) ab_cnt_b++;
    end

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q [$];
    bit          ovf_m;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reference: a command is its words concatenated in arrival order.
    function automatic logic [63:0] pack(input word_arr_t w);
        logic [63:0] v = '0;
        for (int i = 0; i < CB; i++) v = (v << DW) | 64'(w[i]);
        return v;
    endfunction

    function automatic void model_push(input word_arr_t w);
        if (exp_q.size() < FD) exp_q.push_back(pack(w));
        else ovf_m = 1'b1;
    endfunction

    function automatic word_arr_t rand_words();
        word_arr_t w;
        for (int i = 0; i < CB; i++) w[i] = DW'($urandom);
        return w;
    endfunction

    // sel=0: rising-edge bus A; sel=1: falling-edge bus B, where the data
    // is only valid around the falling edge and garbage at the rising edge.
    task automatic drive_word(input bit sel, input logic [DW-1:0] w);
        if (!sel) begin
            ifa.ntr_data = w; tick(3); ifa.ntr_clk = 1'b1; tick(3); ifa.ntr_clk = 1'b0;
        end else begin
            ifb.ntr_data = w; tick(3); ifb.ntr_clk = 1'b0; tick(2);
            ifb.ntr_data = ~w; tick(1); ifb.ntr_clk = 1'b1;
        end
    endtask

    task automatic cs_low(input bit sel);
        if (!sel) ifa.ntr_cs1 = 1'b0; else ifb.ntr_cs1 = 1'b0;
        tick(4);
    endtask

    task automatic cs_high(input bit sel);
        tick(3);
        if (!sel) ifa.ntr_cs1 = 1'b1; else ifb.ntr_cs1 = 1'b1;
        tick(8);
    endtask

    task automatic send_cmd(input bit sel, input word_arr_t w, input int extra);
        cs_low(sel);
        for (int i = 0; i < CB; i++) drive_word(sel, w[i]);
        for (int i = 0; i < extra; i++) drive_word(sel, DW'($urandom));
        cs_high(sel);
    endtask

    task automatic pop_check(input string tag);
        logic [63:0] e;
        e = exp_q.pop_front();
        chk({tag, "_valid"}, 64'(ifa.cmd_valid), 64'd1);
        chk({tag, "_data"}, ifa.cmd_data, e);
        ifa.cmd_ready = 1'b1; tick(1); ifa.cmd_ready = 1'b0;
    endtask

    initial begin
        word_arr_t w;
        int extra;
        int ab0;

        ifa.ntr_clk = 1'b0; ifa.ntr_cs1 = 1'b1; ifa.ntr_data = '0; ifa.cmd_ready = 1'b0;
        ifb.ntr_clk = 1'b1; ifb.ntr_cs1 = 1'b1; ifb.ntr_data = '0; ifb.cmd_ready = 1'b0;
        clr_a = 1'b0; clr_b = 1'b0; ovf_m = 1'b0;

        // Reset state
        tick(3);
        chk("rst_valid", 64'(ifa.cmd_valid), 64'd0);
        chk("rst_level", 64'(lvl_a), 64'd0);
        chk("rst_dcount", 64'(dc_a), 64'd0);
        chk("rst_ovf", 64'(ovf_a), 64'd0);
        chk("rst_abort", 64'(ab_a), 64'd0);
        rst = 1'b0;
        tick(SS + 4);

        // FF,00.. with latency check on the last word
        w = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        cs_low(0);
        for (int i = 0; i < CB - 1; i++) drive_word(0, w[i]);
        ifa.ntr_data = w[CB-1]; tick(3); ifa.ntr_clk = 1'b1;
        tick(SS + 2);
        chk("lat_early", 64'(ifa.cmd_valid), 64'd0);
        tick(1);
        chk("lat_valid", 64'(ifa.cmd_valid), 64'd1);
        tick(2); ifa.ntr_clk = 1'b0;
        cs_high(0);
        model_push(w);
        chk("ff_level", 64'(lvl_a), 64'd1);
        chk("ff_const", ifa.cmd_data, 64'hFF00000000000000);
        pop_check("ff_pop");
        chk("ff_empty", 64'(lvl_a), 64'd0);

        // 01,FF,.. plus 5 data words
        w = '{8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_cmd(0, w, 5);
        model_push(w);
        chk("d5_dcount", 64'(dc_a), 64'd5);
        chk("d5_const", ifa.cmd_data, 64'h01FF000000000000);
        pop_check("d5_pop");

        // Partial command
        ab0 = ab_cnt_a;
        cs_low(0);
        for (int i = 0; i < 3; i++) drive_word(0, DW'($urandom));
        cs_high(0);
        chk("part_abort", 64'(ab_cnt_a - ab0), 64'd1);
        chk("part_level", 64'(lvl_a), 64'd0);

        // Random commands and data lengths
        for (int r = 0; r < 4; r++) begin
            w = rand_words();
            extra = $urandom_range(0, 6);
            send_cmd(0, w, extra);
            model_push(w);
            chk("rnd_dcount", 64'(dc_a), 64'(extra));
            pop_check("rnd_pop");
        end

        // Overflow: FD+1 commands with no consumer
        for (int r = 0; r < FD + 1; r++) begin
            w = rand_words();
            send_cmd(0, w, 0);
            model_push(w);
        end
        chk("ovf_level", 64'(lvl_a), 64'(exp_q.size()));
        chk("ovf_flag", 64'(ovf_a), 64'(ovf_m));
        for (int r = 0; r < FD; r++) pop_check("ovf_pop");
        clr_a = 1'b1; tick(1); clr_a = 1'b0; ovf_m = 1'b0;
        chk("ovf_clear", 64'(ovf_a), 64'd0);

        // Full FIFO, pop coinciding with push
        for (int r = 0; r < FD; r++) begin
            w = rand_words();
            send_cmd(0, w, 0);
            model_push(w);
        end
        w = rand_words();
        cs_low(0);
        for (int i = 0; i < CB - 1; i++) drive_word(0, w[i]);
        ifa.ntr_data = w[CB-1]; tick(3); ifa.ntr_clk = 1'b1;
        tick(SS + 2);
        chk("fp_head", ifa.cmd_data, exp_q[0]);
        ifa.cmd_ready = 1'b1; tick(1); ifa.cmd_ready = 1'b0;
        void'(exp_q.pop_front());
        model_push(w);
        chk("fp_level", 64'(lvl_a), 64'(FD));
        chk("fp_ovf", 64'(ovf_a), 64'd0);
        tick(2); ifa.ntr_clk = 1'b0;
        cs_high(0);
        for (int r = 0; r < FD; r++) pop_check("fp_pop");

        // Reset mid-command, select held low across reset
        cs_low(0);
        for (int i = 0; i < 4; i++) drive_word(0, DW'($urandom));
        rst = 1'b1; tick(3);
        exp_q.delete(); ovf_m = 1'b0;
        chk("mr_level", 64'(lvl_a), 64'd0);
        rst = 1'b0;
        ab0 = ab_cnt_a;
        for (int i = 0; i < CB; i++) drive_word(0, DW'($urandom));
        tick(10);
        chk("mr_ignored", 64'(lvl_a), 64'd0);
        cs_high(0);
        chk("mr_noabort", 64'(ab_cnt_a - ab0), 64'd0);
        w = rand_words();
        send_cmd(0, w, 0);
        model_push(w);
        chk("mr_level1", 64'(lvl_a), 64'd1);
        pop_check("mr_pop");
        chk("mr_empty", 64'(lvl_a), 64'd0);

        // Falling-edge instance
        ab0 = ab_cnt_b;
        w = rand_words();
        send_cmd(1, w, 2);
        chk("fe_level", 64'(lvl_b), 64'd1);
        chk("fe_data", ifb.cmd_data, pack(w));
        chk("fe_dcount", 64'(dc_b), 64'd2);
        chk("fe_noabort", 64'(ab_cnt_b - ab0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
